scratch_line_responder: RTL and testbench

Responder end of the scrypt core's scratchpad port: accepts 1024-bit line read/write requests on the `scratch_*` interface driven by `scrypt_top` and services each one against a narrower single-port, registered-output RAM. Every line is moved as a sequence of 128-bit beats. The block sits between `scrypt_top` and the physical scratchpad RAM, replacing a full-width 1024-bit memory with a narrower, area-cheaper one. It adds a ready/done handshake so the core can stall while a line transfer is in progress.

---
 rtl/scratch_line_responder.sv | 144 ++++++++++++++
 tb/tb_scratch_line_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scratch_line_responder.sv
// scratch_line_responder
//
// Responder for the scrypt core's scratchpad port. Accepts 1024-bit line read or
// write requests and moves each line as a burst of narrow beats to or from a
// single-port RAM with a one-cycle registered read. The core sees a ready/done
// handshake, so it can stall while a line transfer is in progress.
//
// Ports
//   clk            clock, all state changes on its rising edge
//   n_rst          synchronous active-low reset
//   scratch_read   line read request, sampled only while scratch_ready is high
//   scratch_write  line write request, sampled only while scratch_ready is high
//   scratch_addr   line address
//   scratch_in     write line from the core
//   scratch_out    read line to the core, registered; valid from the done cycle
//   scratch_ready  high only when idle
//   scratch_done   one-cycle pulse when a line read or write completes
//   mem_addr       RAM beat address {line, beat}
//   mem_ren        RAM read strobe
//   mem_wen        RAM write strobe
//   mem_wdata      RAM write beat
//   mem_rdata      RAM read beat, valid the cycle after mem_ren

module scratch_line_responder #(
  parameter int unsigned ADDR_BITS = 17,
  parameter int unsigned LINE_BITS = 1024,
  parameter int unsigned BEAT_BITS = 128,
  // Derived; not meant to be overridden.
  parameter int unsigned BEATS     = LINE_BITS / BEAT_BITS,
  parameter int unsigned BEAT_IDX  = $clog2(BEATS)
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          scratch_read,
  input  logic                          scratch_write,
  input  logic [ADDR_BITS-1:0]          scratch_addr,
  input  logic [LINE_BITS-1:0]          scratch_in,
  output logic [LINE_BITS-1:0]          scratch_out,
  output logic                          scratch_ready,
  output logic                          scratch_done,
  output logic [ADDR_BITS+BEAT_IDX-1:0] mem_addr,
  output logic                          mem_ren,
  output logic                          mem_wen,
  output logic [BEAT_BITS-1:0]          mem_wdata,
  input  logic [BEAT_BITS-1:0]          mem_rdata
);

  typedef logic [BEATS-1:0][BEAT_BITS-1:0] line_t;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StWr      = 3'd1;
  localparam logic [2:0] StRd      = 3'd2;
  localparam logic [2:0] StRdDrain = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

  localparam logic [BEAT_IDX-1:0] BeatLast = BEAT_IDX'(BEATS - 1);
  localparam logic [BEAT_IDX-1:0] BeatOne  = BEAT_IDX'(1);

  logic [2:0]           state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q,  addr_d;
  logic [BEAT_IDX-1:0]  beat_q,  beat_d;
  line_t                line_q,  line_d;
  line_t                out_q,   out_d;
  logic [BEAT_IDX-1:0]  cap_idx;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    line_d  = line_q;
    out_d   = out_q;
    // Read data lags the strobe by one cycle, so the beat landing now is the
    // one issued last cycle.
    cap_idx = beat_q - BeatOne;

    case (state_q)
      StIdle: begin
        // Write wins over a simultaneous read; the read is dropped.
        if (scratch_write) begin
          addr_d  = scratch_addr;
          line_d  = scratch_in;
          beat_d  = '0;
          state_d = StWr;
        end else if (scratch_read) begin
          addr_d  = scratch_addr;
          beat_d  = '0;
          state_d = StRd;
        end
      end
      StWr: begin
        beat_d = beat_q + BeatOne;
        if (beat_q == BeatLast) begin
          state_d = StDone;
        end
      end
      StRd: begin
        beat_d = beat_q + BeatOne;
        if (beat_q != '0) begin
          out_d[cap_idx] = mem_rdata;
        end
        if (beat_q == BeatLast) begin
          state_d = StRdDrain;
        end
      end
      StRdDrain: begin
        out_d[BEATS-1] = mem_rdata;
        state_d        = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      beat_q  <= '0;
      line_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      out_q   <= out_d;
    end
  end

  // All RAM-side outputs decode straight from registered state, so the strobes
  // are mutually exclusive by construction.
  assign scratch_out   = out_q;
  assign scratch_ready = (state_q == StIdle);
  assign scratch_done  = (state_q == StDone);
  assign mem_wen       = (state_q == StWr);
  assign mem_ren       = (state_q == StRd);
  assign mem_addr      = {addr_q, beat_q};
  assign mem_wdata     = line_q[beat_q];

endmodule

// File: tb/tb_scratch_line_responder.sv
module tb_scratch_line_responder;

  logic          clk;
  logic          n_rst;
  logic          scratch_read;
  logic          scratch_write;
  logic [16:0]   scratch_addr;
  logic [1023:0] scratch_in;
  logic [1023:0] scratch_out;
  logic          scratch_ready;
  logic          scratch_done;
  logic [19:0]   mem_addr;
  logic          mem_ren;
  logic          mem_wen;
  logic [127:0]  mem_wdata;
  logic [127:0]  mem_rdata;

  scratch_line_responder dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .scratch_read  (scratch_read),
    .scratch_write (scratch_write),
    .scratch_addr  (scratch_addr),
    .scratch_in    (scratch_in),
    .scratch_out   (scratch_out),
    .scratch_ready (scratch_ready),
    .scratch_done  (scratch_done),
    .mem_addr      (mem_addr),
    .mem_ren       (mem_ren),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Small RAM model: lines alias on line[5:0]; the lines used below never collide.
  logic [127:0] ram [512];
  logic         ram_init_done = 1'b0;
  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 512; i++) ram[i] <= '0;
      ram_init_done <= 1'b1;
    end else begin
      if (mem_wen) ram[mem_addr[8:0]] <= mem_wdata;
      if (mem_ren) mem_rdata <= ram[mem_addr[8:0]];
    end
  end

  typedef struct {
    logic         wen;
    logic [19:0]  addr;
    logic [127:0] wdata;
  } strobe_t;

  typedef struct {
    int            cyc;
    logic [1023:0] out;
  } done_t;

  strobe_t       sq[$];
  done_t         dq[$];
  logic [1023:0] model_line [int];
  logic [1023:0] model_out = '0;

  int n_vec = 0;
  int n_fail = 0;
  int done_seen = 0;

  task automatic chk(input string name, input logic ok, input logic [127:0] act,
                     input logic [127:0] exp);
    n_vec++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_line(input string name, input logic [1023:0] act,
                          input logic [1023:0] exp);
    int b = 0;
    for (int k = 7; k >= 0; k--) if (act[128*k +: 128] !== exp[128*k +: 128]) b = k;
    chk(name, act === exp, act[128*b +: 128], exp[128*b +: 128]);
  endtask

  // Monitor: pops expectations whenever the DUT strobes the RAM or signals done.
  initial forever begin
    strobe_t se;
    done_t   de;
    @(negedge clk);
    if (n_rst) begin
      if (mem_wen || mem_ren) begin
        chk("strobe_expected", sq.size() != 0, 128'({mem_wen, mem_ren, mem_addr}), 128'(0));
        if (sq.size() != 0) begin
          se = sq.pop_front();
          chk("strobe_kind", (mem_wen === se.wen) && (mem_ren === !se.wen),
              128'({mem_wen, mem_ren}), 128'({se.wen, !se.wen}));
          chk("mem_addr", mem_addr === se.addr, 128'(mem_addr), 128'(se.addr));
          if (se.wen) chk("mem_wdata", mem_wdata === se.wdata, mem_wdata, se.wdata);
        end
      end
      if (scratch_done) begin
        done_seen++;
        chk("done_expected", dq.size() != 0, 128'(cyc), 128'(0));
        if (dq.size() != 0) begin
          de = dq.pop_front();
          chk("done_cycle", cyc == de.cyc, 128'(cyc), 128'(de.cyc));
          chk_line("scratch_out", scratch_out, de.out);
        end
      end
    end
  end

  function automatic logic [1023:0] pat(input logic [7:0] base);
    logic [1023:0] d;
    for (int k = 0; k < 8; k++) d[128*k +: 128] = {16{8'(base + 8'(k))}};
    return d;
  endfunction

  function automatic logic [1023:0] rnd_line();
    logic [1023:0] d;
    for (int i = 0; i < 32; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  // Called at a negedge; waits for ready, drives one request for one cycle and
  // records the expected strobes and done pulse. Returns at the negedge of cycle 1.
  task automatic issue(input logic wr, input logic rd, input logic [16:0] a,
                       input logic [1023:0] d, output int c0);
    int      w = 0;
    strobe_t se;
    done_t   de;
    while (!scratch_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_issue", scratch_ready === 1'b1, 128'(scratch_ready), 128'(1));
    scratch_write = wr;
    scratch_read  = rd;
    scratch_addr  = a;
    scratch_in    = d;
    c0 = cyc;
    if (wr || rd) begin
      for (int k = 0; k < 8; k++) begin
        se.wen   = wr;
        se.addr  = {a, 3'(k)};
        se.wdata = d[128*k +: 128];
        sq.push_back(se);
      end
      if (wr) begin
        model_line[int'(a)] = d;
        de.cyc = c0 + 9;
      end else begin
        model_out = model_line.exists(int'(a)) ? model_line[int'(a)] : '0;
        de.cyc = c0 + 10;
      end
      de.out = model_out;
      dq.push_back(de);
    end
    @(negedge clk);
    scratch_write = 1'b0;
    scratch_read  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            c0;
    int            w;
    int            d0;
    logic [16:0]   lines [4];
    logic [1023:0] busy_pat;

    n_rst         = 1'b0;
    scratch_read  = 1'b0;
    scratch_write = 1'b0;
    scratch_addr  = '0;
    scratch_in    = '0;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_ready", scratch_ready === 1'b1, 128'(scratch_ready), 128'(1));
    chk("rst_done", scratch_done === 1'b0, 128'(scratch_done), 128'(0));
    chk("rst_out", scratch_out === '0, scratch_out[127:0], 128'(0));
    chk("rst_strobes", {mem_ren, mem_wen} === 2'b00, 128'({mem_ren, mem_wen}), 128'(0));
    chk("rst_mem_addr", mem_addr === '0, 128'(mem_addr), 128'(0));
    chk("rst_mem_wdata", mem_wdata === '0, mem_wdata, 128'(0));
    n_rst = 1'b1;
    @(negedge clk);

    // Write then read line 5: beats at 0x28..0x2F.
    issue(1'b1, 1'b0, 17'h00005, pat(8'h10), c0);
    issue(1'b0, 1'b1, 17'h00005, '0, c0);

    // Busy rejection: pre-load line 2, read line 1, hammer write to 2 in cycles 3-7.
    busy_pat = pat(8'h40);
    issue(1'b1, 1'b0, 17'h00002, busy_pat, c0);
    issue(1'b0, 1'b1, 17'h00001, '0, c0);
    @(negedge clk);
    @(negedge clk);
    scratch_write = 1'b1;
    scratch_addr  = 17'h00002;
    scratch_in    = pat(8'hA0);
    repeat (5) @(negedge clk);
    scratch_write = 1'b0;
    issue(1'b0, 1'b1, 17'h00002, '0, c0);

    // Simultaneous read+write: write wins.
    issue(1'b1, 1'b1, 17'h00003, pat(8'h70), c0);
    issue(1'b0, 1'b1, 17'h00003, '0, c0);

    // Reset in cycle 5 of a read.
    issue(1'b0, 1'b1, 17'h00005, '0, c0);
    repeat (4) @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", scratch_ready === 1'b1, 128'(scratch_ready), 128'(1));
    chk("midrst_done", scratch_done === 1'b0, 128'(scratch_done), 128'(0));
    chk("midrst_out", scratch_out === '0, scratch_out[127:0], 128'(0));
    chk("midrst_strobes", {mem_ren, mem_wen} === 2'b00, 128'({mem_ren, mem_wen}), 128'(0));
    sq.delete();
    dq.delete();
    model_out = '0;
    n_rst = 1'b1;
    @(negedge clk);
    issue(1'b0, 1'b1, 17'h00005, '0, c0);

    // Top line address.
    issue(1'b1, 1'b0, 17'h1FFFF, pat(8'hC0), c0);
    issue(1'b0, 1'b1, 17'h1FFFF, '0, c0);

    // Back-to-back alternating write/read at minimum spacing.
    for (int i = 0; i < 4; i++) lines[i] = 17'(8 + $urandom_range(0, 54));
    w = 0;
    while ((dq.size() != 0) && w < 100) begin
      @(negedge clk);
      w++;
    end
    d0 = done_seen;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) issue(1'b1, 1'b0, lines[$urandom_range(0, 3)], rnd_line(), c0);
      else            issue(1'b0, 1'b1, lines[$urandom_range(0, 3)], '0, c0);
    end

    w = 0;
    while ((dq.size() != 0 || sq.size() != 0) && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("drain_done_q", dq.size() == 0, 128'(dq.size()), 128'(0));
    chk("drain_strobe_q", sq.size() == 0, 128'(sq.size()), 128'(0));
    chk("b2b_done_count", done_seen - d0 == 16, 128'(done_seen - d0), 128'(16));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
